uart_tx_framer: RTL and testbench

Serial transmit stage for the wireless hangman link. Captures bytes presented on `msg` when `ready` rises, queues them in a small FIFO, and serialises each as an 8N1 UART frame on `tx_serial`. The frame format matches what the TxRx receiver/buffer path expects. It sits directly upstream of the receiver's serial input, either via the radio module or looped back on the integration top.

---
 rtl/uart_tx_framer.sv | 126 ++++++++++++
 tb/tb_uart_tx_framer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - byte queue plus 8N1 UART serialiser for the hangman link
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          ready,
  input  logic [7:0]                    msg,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          drop_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_ready_q;
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_busy;
  logic            r_drop;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_write;
  logic            w_bit_end;
  logic [AW:0]     w_count;

  // Queue bookkeeping: pointers carry one extra wrap bit so full and empty differ.
  assign w_push    = ready & ~r_ready_q;
  assign w_count   = r_wr - r_rd;
  assign w_full    = (w_count == FULL_CNT);
  assign w_pop     = (r_state == S_IDLE) && (w_count != '0);
  assign w_write   = w_push && (!w_full || w_pop);
  assign w_bit_end = (r_baud == BAUD_LAST);

  assign fifo_count = w_count;
  assign tx_busy    = r_busy;
  assign drop_err   = r_drop;

  // Ready history resets high so a level already held at reset release is not a push.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_ready_q <= 1'b1;
      r_wr      <= '0;
      r_rd      <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_ready_q <= ready;
      if (w_write) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      if (w_push && !w_write) r_drop <= 1'b1;
    end
  end

  // Byte storage; a write at full with a simultaneous pop reuses the slot being read.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr[AW-1:0]] <= msg;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic: each non-idle state lasts whole bit periods.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_bit_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: line level decoded from registered state so reset forces it high at once.
  always_comb begin
    tx_serial = 1'b1;
    tx_done   = 1'b0;
    case (r_state)
      S_START: tx_serial = 1'b0;
      S_DATA:  tx_serial = r_shift[0];
      S_STOP:  tx_done   = w_bit_end;
      default: tx_serial = 1'b1;
    endcase
  end

  // Baud/bit counters and the shift register holding the byte on the line.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      if (r_state == S_IDLE || w_next != r_state || w_bit_end) r_baud <= '0;
      else                                                      r_baud <= r_baud + CW'(1);
      if (w_pop) r_shift <= r_mem[r_rd[AW-1:0]];
      if (r_state != S_DATA) begin
        r_bit <= '0;
      end else if (w_bit_end && r_bit != 3'd7) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {1'b0, r_shift[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer
module tb_uart_tx_framer;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] msg = 8'h00;
  logic       tx_serial, tx_busy, tx_done, drop_err;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  int   frames = 0, done_cnt = 0, peak = 0, ncyc = 0, last_end = -100, last_gap = 0;
  bit   mon_active = 1'b0;
  int   mon_i = 0;
  logic [7:0]  mon_byte;
  logic [39:0] exp_wave, obs_wave, obs_busy, obs_done;

  always #5 clk = ~clk;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nRst(nRst), .ready(ready), .msg(msg),
    .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done),
    .drop_err(drop_err), .fifo_count(fifo_count)
  );

  // Frame monitor: captures each frame cycle by cycle and compares it with the queued byte.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (tx_done === 1'b1) done_cnt++;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (nRst !== 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx_serial === 1'b0) begin
          mon_active = 1'b1;
          mon_i = 0;
          last_gap = ncyc - last_end - 1;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_frame got=start_bit exp=no_frame at cycle %0d", ncyc);
            mon_byte = 8'h00;
          end else begin
            mon_byte = exp_q.pop_front();
          end
          for (int i = 0; i < FLEN; i++) begin
            int b;
            b = i / CPB;
            exp_wave[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_byte[b-1];
          end
        end
        if (mon_active) begin
          obs_wave[mon_i] = tx_serial;
          obs_busy[mon_i] = tx_busy;
          obs_done[mon_i] = tx_done;
          mon_i++;
          if (mon_i == FLEN) begin
            n_vec++;
            if (obs_wave !== exp_wave) begin
              n_bad++;
              $display("FAIL frame_wave byte=%02h got=%010h exp=%010h", mon_byte, obs_wave, exp_wave);
            end
            n_vec++;
            if (obs_busy !== {40{1'b1}}) begin
              n_bad++;
              $display("FAIL frame_busy byte=%02h got=%010h exp=ffffffffff", mon_byte, obs_busy);
            end
            n_vec++;
            if (obs_done !== 40'h8000000000) begin
              n_bad++;
              $display("FAIL frame_done byte=%02h got=%010h exp=8000000000", mon_byte, obs_done);
            end
            frames++;
            mon_active = 1'b0;
            last_end = ncyc;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit keep, input bit hold);
    ready = 1'b1;
    msg   = b;
    if (keep) exp_q.push_back(b);
    step(1);
    msg = 8'($urandom);
    if (!hold) begin
      ready = 1'b0;
      step(1);
    end
  endtask

  task automatic wait_frames(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !mon_active) break;
      step(1);
    end
    n_vec++;
    if (exp_q.size() != 0 || mon_active) begin
      n_bad++;
      $display("FAIL wait_frames got=%0d_pending exp=0_pending after %0d cycles", exp_q.size(), limit);
      exp_q.delete();
    end
    step(2);
  endtask

  task automatic test_reset;
    step(3);
    n_vec++; if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL rst_tx_serial got=%b exp=1", tx_serial); end
    n_vec++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_tx_busy got=%b exp=0", tx_busy); end
    n_vec++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL rst_tx_done got=%b exp=0", tx_done); end
    n_vec++; if (drop_err !== 1'b0) begin n_bad++; $display("FAIL rst_drop_err got=%b exp=0", drop_err); end
    n_vec++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
    nRst = 1'b1;
    step(3);
    n_vec++; if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL rst_idle_line got=%b exp=1", tx_serial); end
    n_vec++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_idle_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_single_hold;
    int f0, d0;
    step(2);
    f0 = frames; d0 = done_cnt;
    push(8'hA9, 1'b1, 1'b1);
    step(500);
    ready = 1'b0;
    wait_frames(100);
    n_vec++; if (frames - f0 !== 1) begin n_bad++; $display("FAIL single_frames got=%0d exp=1", frames - f0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0); end
    n_vec++; if (drop_err !== 1'b0) begin n_bad++; $display("FAIL single_drop got=%b exp=0", drop_err); end
  endtask

  task automatic test_latency;
    int f0;
    step(2);
    f0 = frames;
    ready = 1'b1; msg = 8'h3C; exp_q.push_back(8'h3C);
    step(1);
    msg = 8'hFF;
    n_vec++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL lat_count_k got=%0d exp=1", fifo_count); end
    n_vec++; if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL lat_line_k got=%b exp=1", tx_serial); end
    n_vec++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_k got=%b exp=0", tx_busy); end
    step(1);
    n_vec++; if (tx_serial !== 1'b0) begin n_bad++; $display("FAIL lat_start_k1 got=%b exp=0", tx_serial); end
    n_vec++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy_k1 got=%b exp=1", tx_busy); end
    n_vec++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL lat_count_k1 got=%0d exp=0", fifo_count); end
    ready = 1'b0;
    wait_frames(100);
    n_vec++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_after got=%b exp=0", tx_busy); end
    n_vec++; if (frames - f0 !== 1) begin n_bad++; $display("FAIL lat_frames got=%0d exp=1", frames - f0); end
  endtask

  task automatic test_back_to_back;
    int f0;
    step(2);
    f0 = frames;
    push(8'hA9, 1'b1, 1'b0);
    step(1);
    push(8'hAA, 1'b1, 1'b0);
    wait_frames(150);
    n_vec++; if (frames - f0 !== 2) begin n_bad++; $display("FAIL b2b_frames got=%0d exp=2", frames - f0); end
    n_vec++; if (last_gap !== 1) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=1", last_gap); end
  endtask

  task automatic test_overflow;
    int f0;
    logic [7:0] bytes [6];
    step(2);
    f0 = frames; peak = 0;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) push(bytes[i], i < 5, 1'b0);
    n_vec++; if (drop_err !== 1'b1) begin n_bad++; $display("FAIL ovf_drop got=%b exp=1", drop_err); end
    n_vec++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    wait_frames(5 * (FLEN + 2) + 50);
    n_vec++; if (frames - f0 !== 5) begin n_bad++; $display("FAIL ovf_frames got=%0d exp=5", frames - f0); end
    n_vec++; if (peak !== 4) begin n_bad++; $display("FAIL ovf_peak got=%0d exp=4", peak); end
  endtask

  task automatic test_sticky;
    int f0;
    step(2);
    f0 = frames;
    push(8'h5E, 1'b1, 1'b0);
    wait_frames(100);
    n_vec++; if (frames - f0 !== 1) begin n_bad++; $display("FAIL sticky_frames got=%0d exp=1", frames - f0); end
    n_vec++; if (drop_err !== 1'b1) begin n_bad++; $display("FAIL sticky_hold got=%b exp=1", drop_err); end
    nRst = 1'b0;
    step(2);
    nRst = 1'b1;
    step(2);
    n_vec++; if (drop_err !== 1'b0) begin n_bad++; $display("FAIL sticky_clear got=%b exp=0", drop_err); end
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    step(2);
    push(8'h5A, 1'b1, 1'b0);
    push(8'h3C, 1'b1, 1'b1);
    step(16);
    #2;
    nRst = 1'b0;
    #1;
    n_vec++; if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL rmf_line got=%b exp=1", tx_serial); end
    n_vec++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rmf_busy got=%b exp=0", tx_busy); end
    n_vec++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rmf_count got=%0d exp=0", fifo_count); end
    exp_q.delete();
    step(3);
    nRst = 1'b1;
    f0 = frames;
    step(100);
    n_vec++; if (frames !== f0) begin n_bad++; $display("FAIL rmf_no_frame got=%0d exp=%0d", frames, f0); end
    n_vec++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rmf_idle_busy got=%b exp=0", tx_busy); end
    n_vec++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rmf_idle_count got=%0d exp=0", fifo_count); end
    ready = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_sticky();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
